ifetcher: RTL and testbench

Instruction fetch unit for the Tomasulo RISC-V core. It holds the PC and keeps a direct-mapped one-word-per-line instruction cache, refilled from the memory controller. It predicts conditional branches with a 2-bit BHT and JAL targets by immediate decode. It is the transmitter side of the instruction stream consumed by `Issue`, and it supplies each instruction with the `IF_jump_flag`/`IF_jump_pc` metadata that `Issue` forwards to the ROB.

---
 rtl/ifetcher.sv | 207 ++++++++++++++++++++
 tb/tb_ifetcher.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetcher.sv
// Instruction fetch unit: PC, direct-mapped one-word-per-line icache refilled from the
// memory controller, 2-bit BHT for conditional branches and JAL target prediction.
//   state     | meaning
//   RUN       | fetch at pc
//   MEM       | icache miss outstanding at MC_addr
//   DRAIN     | flushed during a miss; the response is installed but never issued
//   WAIT_JALR | JALR issued, fetch halted until ROB_clear
module ifetcher #(
    parameter int ICACHE_BITS = 4,
    parameter int BHT_BITS    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        MC_sgn,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_ins,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    output logic        IF_jump_flag,
    output logic [31:0] IF_jump_pc,
    input  logic        ROB_full,
    input  logic        LSB_full,
    input  logic        ROB_clear,
    input  logic [31:0] ROB_clear_pc,
    input  logic        ROB_br_sgn,
    input  logic [31:0] ROB_br_pc,
    input  logic        ROB_br_taken
);
    localparam int LINES = 1 << ICACHE_BITS;
    localparam int TAG_W = 32 - ICACHE_BITS - 2;
    localparam int BHT_N = 1 << BHT_BITS;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef enum logic [1:0] {RUN, MEM, DRAIN, WAIT_JALR} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;

    logic [31:0]      cache_data [LINES];
    logic [TAG_W-1:0] cache_tag  [LINES];
    logic [LINES-1:0] cache_valid;
    logic [1:0]       bht [BHT_N];

    logic [ICACHE_BITS-1:0] ic_idx, fill_idx;
    logic [TAG_W-1:0]       ic_tag, fill_tag;
    logic [BHT_BITS-1:0]    bht_rd_idx, bht_wr_idx;
    logic                   hit, acc, slot_free;

    logic [31:0] fetch_word, bimm, jimm;
    logic        pred;
    logic        dec_flag, dec_jalr;
    logic [31:0] dec_jpc, dec_next;

    logic load_slot, clear_slot, fill, mc_req, mc_drop;
    logic unused_br_bits;

    assign ic_idx     = pc[ICACHE_BITS+1:2];
    assign ic_tag     = pc[31:ICACHE_BITS+2];
    assign fill_idx   = MC_addr[ICACHE_BITS+1:2];
    assign fill_tag   = MC_addr[31:ICACHE_BITS+2];
    assign bht_rd_idx = pc[BHT_BITS+1:2];
    assign bht_wr_idx = ROB_br_pc[BHT_BITS+1:2];
    assign unused_br_bits = ^{ROB_br_pc[31:BHT_BITS+2], ROB_br_pc[1:0]};

    assign hit        = cache_valid[ic_idx] && (cache_tag[ic_idx] == ic_tag);
    assign acc        = IF_ins_sgn && !ROB_full && !LSB_full;
    assign slot_free  = !IF_ins_sgn || acc;
    // In MEM the word comes straight from the controller in the MC_done cycle.
    assign fetch_word = (state == MEM) ? MC_ins : cache_data[ic_idx];

    always_comb begin
        bimm = {{20{fetch_word[31]}}, fetch_word[7], fetch_word[30:25], fetch_word[11:8], 1'b0};
        jimm = {{12{fetch_word[31]}}, fetch_word[19:12], fetch_word[20], fetch_word[30:21], 1'b0};
        pred = bht[bht_rd_idx][1];
        dec_flag = 1'b0;
        dec_jalr = 1'b0;
        dec_jpc  = pc;
        dec_next = pc + 32'd4;
        case (fetch_word[6:0])
            OP_JAL: begin
                dec_flag = 1'b1;
                dec_jpc  = pc + 32'd4;
                dec_next = pc + jimm;
            end
            OP_JALR: begin
                dec_jalr = 1'b1;
                dec_jpc  = pc + 32'd4;
                dec_next = pc;
            end
            OP_BR: begin
                dec_flag = pred;
                dec_jpc  = pred ? pc + 32'd4 : pc + bimm;
                dec_next = pred ? pc + bimm : pc + 32'd4;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_slot  = 1'b0;
        clear_slot = 1'b0;
        fill       = 1'b0;
        mc_req     = 1'b0;
        mc_drop    = 1'b0;
        if (ROB_clear) begin
            clear_slot = 1'b1;
            pc_next    = ROB_clear_pc;
            state_next = RUN;
            if (state == MEM || state == DRAIN) begin
                if (MC_done) begin
                    fill    = 1'b1;
                    mc_drop = 1'b1;
                end else begin
                    state_next = DRAIN;
                end
            end
        end else begin
            case (state)
                RUN: begin
                    if (slot_free) begin
                        if (hit) begin
                            load_slot = 1'b1;
                            pc_next   = dec_next;
                            if (dec_jalr) state_next = WAIT_JALR;
                        end else begin
                            mc_req     = 1'b1;
                            state_next = MEM;
                        end
                    end
                end
                MEM: begin
                    if (MC_done) begin
                        fill       = 1'b1;
                        mc_drop    = 1'b1;
                        load_slot  = 1'b1;
                        pc_next    = dec_next;
                        state_next = dec_jalr ? WAIT_JALR : RUN;
                    end
                end
                DRAIN: begin
                    if (MC_done) begin
                        fill       = 1'b1;
                        mc_drop    = 1'b1;
                        state_next = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pc           <= 32'd0;
            cache_valid  <= '0;
            IF_ins_sgn   <= 1'b0;
            IF_ins       <= 32'd0;
            IF_jump_flag <= 1'b0;
            IF_jump_pc   <= 32'd0;
            MC_sgn       <= 1'b0;
            MC_addr      <= 32'd0;
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
        end else if (rdy) begin
            state <= state_next;
            pc    <= pc_next;
            if (fill) cache_valid[fill_idx] <= 1'b1;
            if (mc_req) begin
                MC_sgn  <= 1'b1;
                MC_addr <= pc;
            end else if (mc_drop) begin
                MC_sgn <= 1'b0;
            end
            if (clear_slot) begin
                IF_ins_sgn <= 1'b0;
            end else if (load_slot) begin
                IF_ins_sgn   <= 1'b1;
                IF_ins       <= fetch_word;
                IF_jump_flag <= dec_flag;
                IF_jump_pc   <= dec_jpc;
            end else if (acc) begin
                IF_ins_sgn <= 1'b0;
            end
            if (ROB_br_sgn) begin
                if (ROB_br_taken && bht[bht_wr_idx] != 2'b11)
                    bht[bht_wr_idx] <= bht[bht_wr_idx] + 2'd1;
                else if (!ROB_br_taken && bht[bht_wr_idx] != 2'b00)
                    bht[bht_wr_idx] <= bht[bht_wr_idx] - 2'd1;
            end
        end
    end

    // Line data and tag need no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            cache_data[fill_idx] <= MC_ins;
            cache_tag[fill_idx]  <= fill_tag;
        end
    end
endmodule

// File: tb/tb_ifetcher.sv
// Randomized scoreboard bench for ifetcher: a program-level model predicts the issued
// instruction stream and the miss addresses; a monitor compares every slot load.
module tb_ifetcher;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        MC_sgn, MC_done;
    logic [31:0] MC_addr, MC_ins;
    logic        IF_ins_sgn, IF_jump_flag;
    logic [31:0] IF_ins, IF_jump_pc;
    logic        ROB_full, LSB_full, ROB_clear, ROB_br_sgn, ROB_br_taken;
    logic [31:0] ROB_clear_pc, ROB_br_pc;

    ifetcher dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .MC_sgn(MC_sgn), .MC_addr(MC_addr), .MC_done(MC_done), .MC_ins(MC_ins),
        .IF_ins_sgn(IF_ins_sgn), .IF_ins(IF_ins), .IF_jump_flag(IF_jump_flag),
        .IF_jump_pc(IF_jump_pc), .ROB_full(ROB_full), .LSB_full(LSB_full),
        .ROB_clear(ROB_clear), .ROB_clear_pc(ROB_clear_pc), .ROB_br_sgn(ROB_br_sgn),
        .ROB_br_pc(ROB_br_pc), .ROB_br_taken(ROB_br_taken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] jpc;
        logic        flag;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          emitted = 0;
    logic [31:0] mem [256];
    logic [1:0]  bht_m [64];
    exp_t        q[$];
    logic [31:0] gen_pc;
    bit          gen_halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the program one instruction from gen_pc, applying the prediction rules.
    function automatic void gen_one();
        logic [31:0] w;
        int          bimm, jimm;
        exp_t        e;
        w    = mem[gen_pc[9:2]];
        bimm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        jimm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        e.pc = gen_pc; e.ins = w; e.flag = 1'b0; e.jpc = gen_pc;
        case (w[6:0])
            7'b1101111: begin e.flag = 1'b1; e.jpc = gen_pc + 4; gen_pc = gen_pc + jimm; end
            7'b1100111: begin e.jpc = gen_pc + 4; gen_halted = 1'b1; end
            7'b1100011: begin
                if (bht_m[gen_pc[7:2]] >= 2) begin
                    e.flag = 1'b1; e.jpc = gen_pc + 4; gen_pc = gen_pc + bimm;
                end else begin
                    e.jpc = gen_pc + bimm; gen_pc = gen_pc + 4;
                end
            end
            default: gen_pc = gen_pc + 4;
        endcase
        q.push_back(e);
    endfunction

    function automatic void refill();
        while (!gen_halted && q.size() < 4) gen_one();
    endfunction

    function automatic void regen(input logic [31:0] start);
        q.delete();
        gen_pc     = start;
        gen_halted = 1'b0;
        refill();
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
        regen(32'd0);
    endfunction

    // Monitor: pre-edge values sampled in the active region, post-edge values 1 ns later.
    logic        p_sgn, p_acc, p_rdy, p_rst, p_clr, p_flag, p_mcs;
    logic [31:0] p_ins, p_jpc, p_mca;
    exp_t        e_pop;
    always @(posedge clk) begin
        p_sgn = IF_ins_sgn; p_acc = IF_ins_sgn && !ROB_full && !LSB_full;
        p_rdy = rdy; p_rst = rst; p_clr = ROB_clear;
        p_ins = IF_ins; p_flag = IF_jump_flag; p_jpc = IF_jump_pc;
        p_mcs = MC_sgn; p_mca = MC_addr;
        #1;
        if (!p_rst && p_rdy) begin
            if (p_clr) begin
                check("flush_clears_slot", IF_ins_sgn, 1'b0);
            end else if (IF_ins_sgn && (!p_sgn || p_acc)) begin
                emitted++;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got ins %h expected no instruction at %0t", IF_ins, $time);
                end else begin
                    e_pop = q.pop_front();
                    check("slot_ins", IF_ins, e_pop.ins);
                    check("slot_flag", IF_jump_flag, e_pop.flag);
                    check("slot_jump_pc", IF_jump_pc, e_pop.jpc);
                    refill();
                end
            end else if (p_sgn && !p_acc) begin
                check("hold_sgn", IF_ins_sgn, 1'b1);
                check("hold_ins", IF_ins, p_ins);
                check("hold_flag", IF_jump_flag, p_flag);
                check("hold_jump_pc", IF_jump_pc, p_jpc);
            end
        end else if (!p_rst) begin
            check("rdy_low_sgn", IF_ins_sgn, p_sgn);
            check("rdy_low_ins", IF_ins, p_ins);
            check("rdy_low_mc_sgn", MC_sgn, p_mcs);
            check("rdy_low_mc_addr", MC_addr, p_mca);
        end
    end

    task automatic reset_checks();
        check("rst_ins_sgn", IF_ins_sgn, 1'b0);
        check("rst_ins", IF_ins, 32'd0);
        check("rst_flag", IF_jump_flag, 1'b0);
        check("rst_jump_pc", IF_jump_pc, 32'd0);
        check("rst_mc_sgn", MC_sgn, 1'b0);
        check("rst_mc_addr", MC_addr, 32'd0);
    endtask

    logic        prev_mcs;
    logic [31:0] prev_mca;
    int          mc_cnt, mc_lat;

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; MC_done = 1'b0; ROB_clear = 1'b0; ROB_br_sgn = 1'b0;
        ROB_full = 1'b0; LSB_full = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_checks();
        rst = 1'b0; prev_mcs = 1'b0; prev_mca = 32'd0; mc_cnt = 0; mc_lat = 3;
    endtask

    task automatic step();
        int i;
        if (MC_sgn && !prev_mcs) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL miss_while_halted: got MC_addr %h expected no request at %0t", MC_addr, $time);
            end else begin
                check("miss_addr", MC_addr, q[0].pc);
            end
        end else if (MC_sgn && prev_mcs) begin
            check("mc_addr_stable", MC_addr, prev_mca);
        end
        prev_mcs = MC_sgn; prev_mca = MC_addr;

        MC_done = 1'b0; ROB_clear = 1'b0; ROB_br_sgn = 1'b0;
        rdy      = ($urandom_range(0, 9) != 0);
        ROB_full = ($urandom_range(0, 9) < 3);
        LSB_full = ($urandom_range(0, 9) == 0);
        if (!rdy) begin
            // Pulses while stalled must be ignored, so the model is left untouched.
            ROB_br_sgn   = ($urandom_range(0, 3) == 0);
            ROB_br_pc    = 32'($urandom_range(0, 255)) << 2;
            ROB_br_taken = 1'($urandom_range(0, 1));
            ROB_clear    = ($urandom_range(0, 7) == 0);
            ROB_clear_pc = 32'($urandom_range(0, 255)) << 2;
            return;
        end
        if (MC_sgn) begin
            mc_cnt++;
            if (mc_cnt >= mc_lat) begin
                MC_done = 1'b1;
                MC_ins  = mem[MC_addr[9:2]];
                mc_cnt  = 0;
                mc_lat  = $urandom_range(1, 4);
            end
        end
        if ($urandom_range(0, 15) == 0) begin
            ROB_clear    = 1'b1;
            ROB_clear_pc = 32'($urandom_range(0, 255)) << 2;
            regen(ROB_clear_pc);
        end else if (IF_ins_sgn && $urandom_range(0, 3) == 0) begin
            // Only while the slot is blocked, so no fetch can race the counter update.
            ROB_full     = 1'b1;
            ROB_br_sgn   = 1'b1;
            ROB_br_pc    = 32'($urandom_range(0, 255)) << 2;
            ROB_br_taken = 1'($urandom_range(0, 1));
            i = int'(ROB_br_pc[7:2]);
            if (ROB_br_taken && bht_m[i] != 2'b11) bht_m[i] = bht_m[i] + 2'd1;
            else if (!ROB_br_taken && bht_m[i] != 2'b00) bht_m[i] = bht_m[i] - 2'd1;
            if (q.size() > 0) regen(q[0].pc);
        end
    endtask

    initial begin
        logic [31:0] w;
        int          r;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            r = $urandom_range(0, 99);
            if (r < 15)      w[6:0] = 7'b1100011;
            else if (r < 22) w[6:0] = 7'b1101111;
            else if (r < 25) w[6:0] = 7'b1100111;
            else if (r < 35) w[6:0] = 7'b0010111;
            else if (r < 65) w[6:0] = 7'b0010011;
            else             w[6:0] = 7'b0110011;
            mem[i] = w;
        end
        mem[0] = 32'h0000_0013;
        MC_ins = 32'd0; ROB_clear_pc = 32'd0; ROB_br_pc = 32'd0; ROB_br_taken = 1'b0;
        do_reset();
        @(negedge clk);
        check("first_req_sgn", MC_sgn, 1'b1);
        check("first_req_addr", MC_addr, 32'd0);
        step();
        for (int c = 1; c < 6000; c++) begin
            @(negedge clk);
            if (c == 3000) do_reset();
            else step();
        end
        check("issued_enough", 32'(emitted > 200), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
